uart_rx_cfg: RTL and testbench

Parametrised UART receiver: a next-generation serial RX front end with configurable data width, parity and stop bits, and framing/parity error reporting. It converts an asynchronous serial line into one data word per frame, qualified by a single-cycle valid pulse. It sits between the board RX pin and the consuming logic (command decoder / FIFO) in the UART subsystem. A break-safe recovery state prevents a held-low line from producing repeated frames.

---
 rtl/uart_rx_cfg.sv | 264 ++++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
//
// Configurable UART receiver front end. Converts the asynchronous RX pin into
// one data word per frame, with a single-cycle valid pulse. Data width,
// parity mode and stop-bit count are parameters. A frame whose stop bit is
// sampled low sends the FSM to a break-wait state, so a line held low
// yields exactly one (erroneous) frame.
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   defined   : each decision uses a 2-of-3 vote over the last three
//               synchronised line values, which rejects one-clock glitches.
//   undefined : the synchroniser output is used directly.
//
// Parameters
//   CLKS_PER_BIT : clocks per bit period (>= 4)
//   DATA_BITS    : data bits per frame, 5..9, LSB first
//   PARITY_MODE  : 0 none, 1 odd, 2 even
//   STOP_BITS    : 1 or 2
//
// Ports
//   i_Clock      : clock, rising edge
//   i_Rst_n      : asynchronous active-low reset
//   i_Rx_Serial  : asynchronous serial input, idles high
//   o_Rx_DV      : one-cycle pulse, frame complete and outputs valid
//   o_Rx_Byte    : received word, held until the next o_Rx_DV
//   o_Parity_Err : parity mismatch of the last frame (0 when parity is off)
//   o_Frame_Err  : a stop bit of the last frame was sampled low
//   o_Busy       : high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    // Mid-start-bit point and full-bit point of the per-bit clock counter.
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic             PARITY_EN = (PARITY_MODE != 0);
    localparam logic             TWO_STOP  = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_DONE     = 3'd5,
        ST_BRK_WAIT = 3'd6
    } state_t;

    // XOR of the received data word together with the received parity bit.
    function automatic logic frame_xor(input logic [DATA_BITS-1:0] word,
                                       input logic                 pbit);
        return (^word) ^ pbit;
    endfunction

    // Parity error: odd mode needs an overall XOR of 1, even mode of 0.
    function automatic logic parity_error(input logic [DATA_BITS-1:0] word,
                                          input logic                 pbit);
        logic x;
        logic err;
        x = frame_xor(word, pbit);
        if (PARITY_MODE == 1) begin
            err = (x == 1'b0);
        end else if (PARITY_MODE == 2) begin
            err = (x == 1'b1);
        end else begin
            err = 1'b0;
        end
        return err;
    endfunction

    // 2-of-3 majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [1:0]           sync_r;
    logic                 line_s;
    logic                 tick_s;
    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [IDX_W-1:0]     idx_r;
    logic                 stop_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_bit_r;
    logic                 ferr_flag_r;

    // Two-flop synchroniser for the asynchronous RX pin; idles high.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], i_Rx_Serial};
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // The vote window is the synchroniser output plus its two previous
    // values, so the window is a 3-deep chain ending at sync_r[1].
    logic [1:0] hist_r;

    // History of the synchronised line feeding the majority vote.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            hist_r <= 2'b11;
        end else begin
            hist_r <= {hist_r[0], sync_r[1]};
        end
    end

    assign line_s = maj3(sync_r[1], hist_r[0], hist_r[1]);
`else
    assign line_s = sync_r[1];
`endif

    // Full bit period elapsed: sample point for data, parity and stop bits.
    assign tick_s = (cnt_r == LAST_CNT);

    // Receive FSM with registered outputs.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            idx_r        <= '0;
            stop_idx_r   <= 1'b0;
            shift_r      <= '0;
            par_bit_r    <= 1'b0;
            ferr_flag_r  <= 1'b0;
            o_Rx_DV      <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Busy       <= 1'b0;
        end else begin
            o_Rx_DV <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r       <= '0;
                    idx_r       <= '0;
                    stop_idx_r  <= 1'b0;
                    ferr_flag_r <= 1'b0;
                    if (!line_s) begin
                        state_r <= ST_START;
                        o_Busy  <= 1'b1;
                    end else begin
                        o_Busy  <= 1'b0;
                    end
                end

                // Re-check the line half a bit in; a high level was a glitch.
                ST_START: begin
                    if (cnt_r == HALF_CNT) begin
                        cnt_r <= '0;
                        if (!line_s) begin
                            state_r <= ST_DATA;
                            o_Busy  <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            o_Busy  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end

                // LSB-first: shifting right places the first sample in bit 0
                // once all DATA_BITS samples have been taken.
                ST_DATA: begin
                    if (tick_s) begin
                        cnt_r   <= '0;
                        shift_r <= {line_s, shift_r[DATA_BITS-1:1]};
                        if (idx_r == LAST_IDX) begin
                            idx_r   <= '0;
                            state_r <= PARITY_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end

                ST_PARITY: begin
                    if (tick_s) begin
                        cnt_r     <= '0;
                        par_bit_r <= line_s;
                        state_r   <= ST_STOP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end

                // Any low stop sample latches the frame error until IDLE.
                ST_STOP: begin
                    if (tick_s) begin
                        cnt_r <= '0;
                        if (!line_s) begin
                            ferr_flag_r <= 1'b1;
                        end else begin
                            ferr_flag_r <= ferr_flag_r;
                        end
                        if (TWO_STOP && !stop_idx_r) begin
                            stop_idx_r <= 1'b1;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end

                // Publish the frame one clock after the final stop sample.
                ST_DONE: begin
                    o_Rx_DV      <= 1'b1;
                    o_Rx_Byte    <= shift_r;
                    o_Parity_Err <= parity_error(shift_r, par_bit_r);
                    o_Frame_Err  <= ferr_flag_r;
                    if (ferr_flag_r) begin
                        state_r <= ST_BRK_WAIT;
                        o_Busy  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        o_Busy  <= 1'b0;
                    end
                end

                // A held-low line must go high before a new start is accepted.
                ST_BRK_WAIT: begin
                    if (line_s) begin
                        state_r <= ST_IDLE;
                        o_Busy  <= 1'b0;
                    end else begin
                        o_Busy  <= 1'b1;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    idx_r   <= '0;
                    o_Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_cfg
//
// Three receiver instances with different frame formats share clock and
// reset: A = 8N1 at 87 clk/bit, B = 7E1 at 16 clk/bit, C = 8N2 at 16 clk/bit.
// Frames are built as plain bit lists from the UART framing rules, driven on
// the instance's own line, and every o_Rx_DV is logged with its cycle number.
// Expected word, error flags and latency come from the framing rules.
// -----------------------------------------------------------------------------
module tb_uart_rx_cfg;

    logic clk;
    logic rst_n;
    logic rx_line [0:2];

    logic       dv_a, perr_a, ferr_a, busy_a;
    logic [7:0] byte_a;
    logic       dv_b, perr_b, ferr_b, busy_b;
    logic [6:0] byte_b;
    logic       dv_c, perr_c, ferr_c, busy_c;
    logic [7:0] byte_c;

    int check_cnt = 0;
    int fail_cnt  = 0;
    int cyc       = 0;
    int dbl_cnt   = 0;
    logic dv_prev_a = 1'b0;
    logic dv_prev_b = 1'b0;
    logic dv_prev_c = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] perr;
        logic [31:0] ferr;
        int          cyc;
    } rx_ev_t;

    rx_ev_t q_a[$];
    rx_ev_t q_b[$];
    rx_ev_t q_c[$];

    uart_rx_cfg #(.CLKS_PER_BIT(87), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut_a (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_line[0]),
        .o_Rx_DV(dv_a), .o_Rx_Byte(byte_a), .o_Parity_Err(perr_a),
        .o_Frame_Err(ferr_a), .o_Busy(busy_a));

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) u_dut_b (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_line[1]),
        .o_Rx_DV(dv_b), .o_Rx_Byte(byte_b), .o_Parity_Err(perr_b),
        .o_Frame_Err(ferr_b), .o_Busy(busy_b));

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_dut_c (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_line[2]),
        .o_Rx_DV(dv_c), .o_Rx_Byte(byte_c), .o_Parity_Err(perr_c),
        .o_Frame_Err(ferr_c), .o_Busy(busy_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter: number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Log every valid pulse on the falling edge and catch pulses wider than one clock.
    always @(negedge clk) begin
        rx_ev_t ev;
        if (dv_a) begin
            ev.data = 32'(byte_a); ev.perr = 32'(perr_a); ev.ferr = 32'(ferr_a); ev.cyc = cyc;
            q_a.push_back(ev);
        end
        if (dv_b) begin
            ev.data = 32'(byte_b); ev.perr = 32'(perr_b); ev.ferr = 32'(ferr_b); ev.cyc = cyc;
            q_b.push_back(ev);
        end
        if (dv_c) begin
            ev.data = 32'(byte_c); ev.perr = 32'(perr_c); ev.ferr = 32'(ferr_c); ev.cyc = cyc;
            q_c.push_back(ev);
        end
        if ((dv_a && dv_prev_a) || (dv_b && dv_prev_b) || (dv_c && dv_prev_c))
            dbl_cnt <= dbl_cnt + 1;
        dv_prev_a <= dv_a;
        dv_prev_b <= dv_b;
        dv_prev_c <= dv_c;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int cpb_of(input int sel);
        return (sel == 0) ? 87 : 16;
    endfunction
    function automatic int nd_of(input int sel);
        return (sel == 1) ? 7 : 8;
    endfunction
    function automatic int pm_of(input int sel);
        return (sel == 1) ? 2 : 0;
    endfunction
    function automatic int ns_of(input int sel);
        return (sel == 2) ? 2 : 1;
    endfunction

    function automatic int qsize(input int sel);
        if (sel == 0) return q_a.size();
        else if (sel == 1) return q_b.size();
        else return q_c.size();
    endfunction

    function automatic rx_ev_t qpop(input int sel);
        if (sel == 0) return q_a.pop_front();
        else if (sel == 1) return q_b.pop_front();
        else return q_c.pop_front();
    endfunction

    // Frame as a list of line levels, LSB first: start, data, [parity], stops.
    function automatic logic [15:0] build_bits(input int sel, input int data, input logic pbit,
                                               input logic [1:0] stops, output int nbits);
        logic [15:0] b;
        int k;
        b = 16'hFFFF;
        b[0] = 1'b0;
        k = 1;
        for (int i = 0; i < nd_of(sel); i++) begin
            b[k] = data[i];
            k++;
        end
        if (pm_of(sel) != 0) begin
            b[k] = pbit;
            k++;
        end
        for (int i = 0; i < ns_of(sel); i++) begin
            b[k] = stops[i];
            k++;
        end
        nbits = k;
        return b;
    endfunction

    // Drive a frame, one level per bit period; optionally invert a single clock.
    task automatic drive_frame(input int sel, input logic [15:0] bits, input int nbits,
                               input int glitch_bit, input int glitch_off);
        for (int i = 0; i < nbits; i++) begin
            for (int j = 0; j < cpb_of(sel); j++) begin
                rx_line[sel] = bits[i] ^ ((i == glitch_bit) && (j == glitch_off));
                @(negedge clk);
            end
        end
    endtask

    // Pop the next logged frame and compare it with the expectation.
    // t0 is the cycle count at the moment the start bit was driven; the
    // following rising edge is the first to capture it.
    task automatic expect_next(input string tag, input int sel, input int exp_data,
                               input int exp_perr, input int exp_ferr, input int t0, input int nsym);
        rx_ev_t ev;
        int cpb;
        int lat;
        int obs_lat;
        logic ok;
        cpb = cpb_of(sel);
        lat = 3 + (cpb - 1) / 2 + 1 + nsym * cpb;
        check_eq({tag, "_dv_seen"}, 32'(qsize(sel) != 0), 32'd1);
        if (qsize(sel) != 0) begin
            ev = qpop(sel);
            check_eq({tag, "_data"}, ev.data, 32'(exp_data));
            check_eq({tag, "_perr"}, ev.perr, 32'(exp_perr));
            check_eq({tag, "_ferr"}, ev.ferr, 32'(exp_ferr));
            obs_lat = ev.cyc - t0 - 1;
            ok = (obs_lat >= lat - 1) && (obs_lat <= lat + 1);
            if (!ok) $display("  %s latency observed %0d clocks, formula %0d", tag, obs_lat, lat);
            check_eq({tag, "_lat_ok"}, 32'(ok), 32'd1);
        end
    endtask

    // Send one frame with the correct parity (optionally flipped) and given
    // stop levels, idle for idle_bits bit periods, then check exactly one DV.
    task automatic send_check(input string tag, input int sel, input int data_in, input logic pflip,
                              input logic [1:0] stops, input int idle_bits);
        logic [15:0] bits;
        int nbits, t0, data, exp_perr, exp_ferr;
        logic pbit, x;
        data = data_in & ((1 << nd_of(sel)) - 1);
        // Correct parity bit makes the total XOR 1 (odd) or 0 (even).
        pbit = (pm_of(sel) == 1) ? ~(^data) : (^data);
        pbit = pbit ^ pflip;
        bits = build_bits(sel, data, pbit, stops, nbits);
        x = (^data) ^ pbit;
        if (pm_of(sel) == 1) exp_perr = (x == 1'b0) ? 1 : 0;
        else if (pm_of(sel) == 2) exp_perr = (x == 1'b1) ? 1 : 0;
        else exp_perr = 0;
        exp_ferr = ((stops[0] == 1'b0) || (ns_of(sel) == 2 && stops[1] == 1'b0)) ? 1 : 0;
        t0 = cyc;
        drive_frame(sel, bits, nbits, -1, 0);
        rx_line[sel] = 1'b1;
        repeat (idle_bits * cpb_of(sel)) @(negedge clk);
        check_eq({tag, "_count"}, 32'(qsize(sel)), 32'd1);
        expect_next(tag, sel, data, exp_perr, exp_ferr, t0, nbits - 1);
    endtask

    initial begin
        logic [15:0] bits;
        int nbits, t0, idle;
        logic [1:0] stops;
        logic pflip;

        rst_n = 1'b0;
        rx_line[0] = 1'b1;
        rx_line[1] = 1'b1;
        rx_line[2] = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst_dv_a",   32'(dv_a),   32'd0);
        check_eq("rst_byte_a", 32'(byte_a), 32'd0);
        check_eq("rst_busy_a", 32'(busy_a), 32'd0);
        check_eq("rst_perr_b", 32'(perr_b), 32'd0);
        check_eq("rst_ferr_c", 32'(ferr_c), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 basic frame.
        send_check("a5", 0, 8'hA5, 1'b0, 2'b11, 2);

        // Start glitch: low for only 20 clocks.
        t0 = cyc;
        rx_line[0] = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("glitch_busy_hi", 32'(busy_a), 32'd1);
        repeat (10) @(negedge clk);
        rx_line[0] = 1'b1;
        while (cyc - t0 - 1 < 48) @(negedge clk);
        check_eq("glitch_busy_lo", 32'(busy_a), 32'd0);
        repeat (2 * 87) @(negedge clk);
        check_eq("glitch_no_dv", 32'(q_a.size()), 32'd0);

        // Break: line held low for 20 bit periods yields one errored frame.
        t0 = cyc;
        rx_line[0] = 1'b0;
        repeat (20 * 87) @(negedge clk);
        check_eq("brk_count", 32'(q_a.size()), 32'd1);
        check_eq("brk_busy", 32'(busy_a), 32'd1);
        expect_next("brk", 0, 0, 0, 1, t0, 9);
        rx_line[0] = 1'b1;
        repeat (2 * 87) @(negedge clk);
        check_eq("brk_no_more", 32'(q_a.size()), 32'd0);
        check_eq("brk_idle", 32'(busy_a), 32'd0);
        send_check("after_brk", 0, 8'h3C, 1'b0, 2'b11, 2);

        // 0xFF with a one-clock low pulse on data bit 3 (frame bit 4). The
        // samples fall (CPB-1)/2+3 clocks into each bit and the line passes
        // two synchroniser flops, so the pin is read 1+(CPB-1)/2 clocks in.
        bits = build_bits(0, 8'hFF, 1'b0, 2'b11, nbits);
        t0 = cyc;
        drive_frame(0, bits, nbits, 4, 1 + (87 - 1) / 2);
        rx_line[0] = 1'b1;
        repeat (2 * 87) @(negedge clk);
        check_eq("spike_count", 32'(q_a.size()), 32'd1);
`ifdef UART_RX_MAJORITY_EN
        expect_next("spike", 0, 8'hFF, 0, 0, t0, 9);
`else
        expect_next("spike", 0, 8'hF7, 0, 0, t0, 9);
`endif

        // Random 8N1 frames.
        for (int n = 0; n < 6; n++)
            send_check("rnd_a", 0, int'($urandom_range(255)), 1'b0, 2'b11, int'($urandom_range(2)));

        // Reset in the middle of data bit 4 discards the frame.
        bits = build_bits(0, 8'hC3, 1'b0, 2'b11, nbits);
        drive_frame(0, bits, 5, -1, 0);
        rx_line[0] = bits[5];
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        rx_line[0] = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("mid_rst_dv",   32'(dv_a),   32'd0);
        check_eq("mid_rst_byte", 32'(byte_a), 32'd0);
        check_eq("mid_rst_perr", 32'(perr_a), 32'd0);
        check_eq("mid_rst_ferr", 32'(ferr_a), 32'd0);
        check_eq("mid_rst_busy", 32'(busy_a), 32'd0);
        rst_n = 1'b1;
        repeat (2 * 87) @(negedge clk);
        check_eq("mid_rst_no_dv", 32'(q_a.size()), 32'd0);
        send_check("after_rst", 0, 8'h5A, 1'b0, 2'b11, 2);

        // 7E1: wrong then correct parity on 0x41, then random frames.
        send_check("par_bad", 1, 8'h41, 1'b1, 2'b11, 2);
        send_check("par_ok",  1, 8'h41, 1'b0, 2'b11, 2);
        for (int n = 0; n < 16; n++) begin
            pflip = 1'($urandom_range(1));
            stops = {1'b1, ($urandom_range(4) == 0) ? 1'b0 : 1'b1};
            idle = (stops[0] == 1'b0) ? 1 + int'($urandom_range(1)) : int'($urandom_range(2));
            send_check("rnd_b", 1, int'($urandom_range(127)), pflip, stops, idle);
        end

        // 8N2: back-to-back frames, then random frames with random stop levels.
        send_check("b2b_12", 2, 8'h12, 1'b0, 2'b11, 0);
        send_check("b2b_34", 2, 8'h34, 1'b0, 2'b11, 1);
        for (int n = 0; n < 12; n++) begin
            stops = {($urandom_range(5) == 0) ? 1'b0 : 1'b1, ($urandom_range(5) == 0) ? 1'b0 : 1'b1};
            idle = (stops != 2'b11) ? 1 + int'($urandom_range(1)) : int'($urandom_range(2));
            send_check("rnd_c", 2, int'($urandom_range(255)), 1'b0, stops, idle);
        end

        repeat (20) @(negedge clk);
        check_eq("dv_single_cycle", 32'(dbl_cnt), 32'd0);
        check_eq("stray_dv", 32'(q_a.size() + q_b.size() + q_c.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
